// File: rtl/bout_judge.sv
// rtl/bout_judge.sv - referee for a two-player bout: punch detection, block/counter rules,
// health, round timer and result.
module bout_judge #(
    parameter int HP_INIT     = 5,
    parameter int HP_W        = 3,
    parameter int DMG         = 1,
    parameter int CNT_DMG     = 2,
    parameter int ROUND_TICKS = 60,
    parameter int T_W         = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick,
    input  logic            start,
    input  logic [1:0]      p1_state,
    input  logic [1:0]      p2_state,
    output logic [HP_W-1:0] p1_hp,
    output logic [HP_W-1:0] p2_hp,
    output logic            p1_hit,
    output logic            p2_hit,
    output logic            p1_blk,
    output logic            p2_blk,
    output logic [T_W-1:0]  time_left,
    output logic [1:0]      phase,
    output logic [1:0]      winner
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FIGHT = 2'b01,
        DONE  = 2'b10
    } phase_t;

    localparam logic [1:0] ST_DEF   = 2'b01;
    localparam logic [1:0] ST_ATK   = 2'b10;
    localparam logic [1:0] ST_PUNCH = 2'b11;

    localparam logic [HP_W-1:0] HP_RELOAD  = HP_W'(HP_INIT);
    localparam logic [HP_W-1:0] DMG_N      = HP_W'(DMG);
    localparam logic [HP_W-1:0] DMG_C      = HP_W'(CNT_DMG);
    localparam logic [T_W-1:0]  TIME_RELOAD = T_W'(ROUND_TICKS);

    phase_t          state_q, state_d;
    logic [1:0]      prev1_q, prev2_q;
    logic [HP_W-1:0] p1_hp_q, p1_hp_d, p2_hp_q, p2_hp_d;
    logic [T_W-1:0]  time_q, time_d;
    logic [1:0]      winner_q, winner_d;
    logic            p1_hit_q, p1_hit_d, p2_hit_q, p2_hit_d;
    logic            p1_blk_q, p1_blk_d, p2_blk_q, p2_blk_d;
    logic            ev1, ev2, timeout;

    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp,
                                                input logic [HP_W-1:0] d);
        return (hp <= d) ? '0 : hp - d;
    endfunction

    // Rising edge into the punching state; gated by phase in the FSM below.
    assign ev1 = (p1_state == ST_PUNCH) && (prev1_q != ST_PUNCH);
    assign ev2 = (p2_state == ST_PUNCH) && (prev2_q != ST_PUNCH);

    always_comb begin
        state_d  = state_q;
        p1_hp_d  = p1_hp_q;
        p2_hp_d  = p2_hp_q;
        time_d   = time_q;
        winner_d = winner_q;
        p1_hit_d = 1'b0;
        p2_hit_d = 1'b0;
        p1_blk_d = 1'b0;
        p2_blk_d = 1'b0;
        timeout  = 1'b0;
        case (state_q)
            FIGHT: begin
                if (ev1) begin
                    if (p2_state == ST_DEF) begin
                        p2_blk_d = 1'b1;
                    end else begin
                        p2_hit_d = 1'b1;
                        p2_hp_d  = sat_sub(p2_hp_q, (p2_state == ST_ATK) ? DMG_C : DMG_N);
                    end
                end
                if (ev2) begin
                    if (p1_state == ST_DEF) begin
                        p1_blk_d = 1'b1;
                    end else begin
                        p1_hit_d = 1'b1;
                        p1_hp_d  = sat_sub(p1_hp_q, (p1_state == ST_ATK) ? DMG_C : DMG_N);
                    end
                end
                if (tick && time_q != '0) begin
                    time_d  = time_q - 1'b1;
                    timeout = (time_q == T_W'(1));
                end
                // KO outranks timeout when both land in the same cycle.
                if (p1_hp_d == '0 && p2_hp_d == '0) begin
                    state_d  = DONE;
                    winner_d = 2'b11;
                end else if (p2_hp_d == '0) begin
                    state_d  = DONE;
                    winner_d = 2'b01;
                end else if (p1_hp_d == '0) begin
                    state_d  = DONE;
                    winner_d = 2'b10;
                end else if (timeout) begin
                    state_d  = DONE;
                    if (p1_hp_d > p2_hp_d)      winner_d = 2'b01;
                    else if (p2_hp_d > p1_hp_d) winner_d = 2'b10;
                    else                        winner_d = 2'b11;
                end
            end
            default: begin
                if (start) begin
                    state_d  = FIGHT;
                    p1_hp_d  = HP_RELOAD;
                    p2_hp_d  = HP_RELOAD;
                    time_d   = TIME_RELOAD;
                    winner_d = 2'b00;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            prev1_q  <= 2'b00;
            prev2_q  <= 2'b00;
            p1_hp_q  <= HP_RELOAD;
            p2_hp_q  <= HP_RELOAD;
            time_q   <= TIME_RELOAD;
            winner_q <= 2'b00;
            p1_hit_q <= 1'b0;
            p2_hit_q <= 1'b0;
            p1_blk_q <= 1'b0;
            p2_blk_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev1_q  <= p1_state;
            prev2_q  <= p2_state;
            p1_hp_q  <= p1_hp_d;
            p2_hp_q  <= p2_hp_d;
            time_q   <= time_d;
            winner_q <= winner_d;
            p1_hit_q <= p1_hit_d;
            p2_hit_q <= p2_hit_d;
            p1_blk_q <= p1_blk_d;
            p2_blk_q <= p2_blk_d;
        end
    end

    assign p1_hp     = p1_hp_q;
    assign p2_hp     = p2_hp_q;
    assign p1_hit    = p1_hit_q;
    assign p2_hit    = p2_hit_q;
    assign p1_blk    = p1_blk_q;
    assign p2_blk    = p2_blk_q;
    assign time_left = time_q;
    assign phase     = state_q;
    assign winner    = winner_q;

endmodule

// File: tb/tb_bout_judge.sv
// tb/tb_bout_judge.sv - directed self-checking bench for bout_judge.
module tb_bout_judge;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic [1:0] p1_state = 2'b00;
    logic [1:0] p2_state = 2'b00;
    logic [2:0] p1_hp, p2_hp;
    logic       p1_hit, p2_hit, p1_blk, p2_blk;
    logic [5:0] time_left;
    logic [1:0] phase, winner;

    int errors = 0;
    int checks = 0;

    bout_judge dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start),
        .p1_state(p1_state), .p2_state(p2_state),
        .p1_hp(p1_hp), .p2_hp(p2_hp),
        .p1_hit(p1_hit), .p2_hit(p2_hit), .p1_blk(p1_blk), .p2_blk(p2_blk),
        .time_left(time_left), .phase(phase), .winner(winner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [1:0] s1, input logic [1:0] s2);
        p1_state = s1;
        p2_state = s2;
        cyc();
    endtask

    task automatic rest();
        drive(2'b00, 2'b00);
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        cyc(n);
        tick = 1'b0;
    endtask

    task automatic begin_round();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic chk_state(input string tag, input int h1, input int h2, input int t,
                             input int ph, input int w);
        chk({tag, "_p1hp"}, p1_hp, h1);
        chk({tag, "_p2hp"}, p2_hp, h2);
        chk({tag, "_time"}, time_left, t);
        chk({tag, "_phase"}, phase, ph);
        chk({tag, "_winner"}, winner, w);
    endtask

    task automatic chk_pulses(input string tag, input logic h1, input logic h2,
                              input logic b1, input logic b2);
        chk({tag, "_p1hit"}, p1_hit, h1);
        chk({tag, "_p2hit"}, p2_hit, h2);
        chk({tag, "_p1blk"}, p1_blk, b1);
        chk({tag, "_p2blk"}, p2_blk, b2);
    endtask

    initial begin
        cyc();
        chk_state("reset", 5, 5, 60, 0, 0);
        chk_pulses("reset", 0, 0, 0, 0);
        rst = 1'b0;

        begin_round();
        chk_state("start", 5, 5, 60, 1, 0);

        drive(2'b11, 2'b00);
        chk_state("hit", 5, 4, 60, 1, 0);
        chk_pulses("hit", 0, 1, 0, 0);
        rest();
        chk_pulses("hit_end", 0, 0, 0, 0);

        drive(2'b11, 2'b01);
        chk("blk_p2hp", p2_hp, 4);
        chk_pulses("blk", 0, 0, 0, 1);
        rest();
        chk_pulses("blk_end", 0, 0, 0, 0);

        drive(2'b11, 2'b10);
        chk("cnt_p2hp", p2_hp, 2);
        chk_pulses("cnt", 0, 1, 0, 0);
        rest();

        drive(2'b11, 2'b11);
        chk_state("both", 4, 1, 60, 1, 0);
        chk_pulses("both", 1, 1, 0, 0);
        p2_state = 2'b00;
        cyc(5);
        chk_state("hold", 4, 1, 60, 1, 0);
        chk_pulses("hold", 0, 0, 0, 0);
        rest();

        drive(2'b11, 2'b00);
        chk_state("ko", 4, 0, 60, 2, 1);
        rest();
        drive(2'b00, 2'b11);
        chk_state("done_ign", 4, 0, 60, 2, 1);
        chk("done_ign_p1hit", p1_hit, 0);
        rest();
        begin_round();
        chk_state("restart", 5, 5, 60, 1, 0);

        drive(2'b11, 2'b11); rest();
        drive(2'b11, 2'b11); rest();
        chk_state("pre_to_draw", 3, 3, 60, 1, 0);
        ticks(59);
        chk_state("to_draw_59", 3, 3, 1, 1, 0);
        ticks(1);
        chk_state("to_draw", 3, 3, 0, 2, 3);
        cyc(2);
        chk("to_draw_hold_time", time_left, 0);

        begin_round();
        drive(2'b11, 2'b10); rest();
        drive(2'b11, 2'b00); rest();
        drive(2'b00, 2'b11); rest();
        chk_state("pre_to_p1", 4, 2, 60, 1, 0);
        ticks(60);
        chk_state("to_p1", 4, 2, 0, 2, 1);

        begin_round();
        drive(2'b10, 2'b11); rest();
        chk("cnt_p1hp", p1_hp, 3);
        ticks(60);
        chk_state("to_p2", 3, 5, 0, 2, 2);

        begin_round();
        drive(2'b11, 2'b10); rest();
        drive(2'b11, 2'b10); rest();
        chk("pre_ko_tick_p2hp", p2_hp, 1);
        ticks(59);
        chk("pre_ko_tick_time", time_left, 1);
        p1_state = 2'b11;
        ticks(1);
        chk_state("ko_tick", 5, 0, 0, 2, 1);
        rest();

        begin_round();
        drive(2'b11, 2'b10); rest();
        drive(2'b11, 2'b10); rest();
        drive(2'b10, 2'b11); rest();
        drive(2'b10, 2'b11); rest();
        drive(2'b11, 2'b11);
        chk_state("double_ko", 0, 0, 60, 2, 3);
        rest();

        begin_round();
        drive(2'b10, 2'b11); rest();
        drive(2'b00, 2'b11); rest();
        drive(2'b11, 2'b00); rest();
        ticks(43);
        chk_state("pre_rst", 2, 4, 17, 1, 0);
        rst = 1'b1; tick = 1'b1; start = 1'b1; p1_state = 2'b11;
        cyc();
        chk_state("mid_rst", 5, 5, 60, 0, 0);
        chk_pulses("mid_rst", 0, 0, 0, 0);
        rst = 1'b0; tick = 1'b0; start = 1'b0;
        cyc();
        chk("post_rst_phase", phase, 0);

        begin_round();
        cyc(2);
        chk("entry_hold_p2hp", p2_hp, 5);
        chk("entry_hold_p2hit", p2_hit, 0);
        rest();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
